xpb_reduce_accum: RTL and testbench

//  Sequential reduction accumulator for the modular-squaring datapath. Takes the low DATA_W bits of a

---
 rtl/xpb_reduce_accum_if.sv | 37 +++
 rtl/xpb_reduce_accum.sv | 111 +++++++++++
 tb/tb_xpb_reduce_accum.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xpb_reduce_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : xpb_reduce_accum_if
// Description : Operand, xpb-table and result bundle for xpb_reduce_accum.
// Revision    : 1.0 - initial release
// ============================================================================
interface xpb_reduce_accum_if #(
    parameter int DATA_W  = 1024,
    parameter int SEG_W   = 5,
    parameter int NUM_SEG = 32,
    parameter int GUARD   = 8,
    parameter int IDX_W   = 6
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_low;
    logic [NUM_SEG*SEG_W-1:0]   in_high;
    logic [IDX_W-1:0]           xpb_seg_idx;
    logic [SEG_W-1:0]           xpb_sel;
    logic [DATA_W-1:0]          xpb_value;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W+GUARD-1:0]    out_data;

    // Upstream producer, table bank and downstream consumer side.
    modport master (
        output in_valid, in_low, in_high, xpb_value, out_ready,
        input  in_ready, xpb_seg_idx, xpb_sel, out_valid, out_data
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_low, in_high, xpb_value, out_ready,
        output in_ready, xpb_seg_idx, xpb_sel, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/xpb_reduce_accum.sv
`default_nettype none
// ============================================================================
// Module      : xpb_reduce_accum
// Description : Walks the high segments through the xpb table bank and adds
//               the residues onto the low part in carry-save form.
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_reduce_accum #(
    parameter int DATA_W  = 1024,
    parameter int SEG_W   = 5,
    parameter int NUM_SEG = 32,
    parameter int GUARD   = 8,
    parameter int IDX_W   = 6
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    xpb_reduce_accum_if.slave   bus
);
    localparam int c_ACC_W  = DATA_W + GUARD;
    localparam int c_HIGH_W = NUM_SEG * SEG_W;
    localparam logic [IDX_W-1:0] c_LAST_SEG = IDX_W'(NUM_SEG - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCUM   = 2'd1;
    localparam logic [1:0] c_ST_RESOLVE = 2'd2;
    localparam logic [1:0] c_ST_HOLD    = 2'd3;

    logic [1:0]           r_state;
    logic [c_HIGH_W-1:0]  r_shift;
    logic [IDX_W-1:0]     r_seg_cnt;
    logic [SEG_W-1:0]     r_sel;
    logic [c_ACC_W-1:0]   r_sum;
    logic [c_ACC_W-1:0]   r_carry;
    logic [c_ACC_W-1:0]   r_out_data;
    logic                 r_out_valid;

    logic [c_ACC_W-1:0]   w_addend;
    logic [c_ACC_W-1:0]   w_carry_sh;
    logic [c_ACC_W-1:0]   w_csa_sum;
    logic [c_ACC_W-1:0]   w_csa_carry;
    logic                 w_accept;

    assign w_accept    = (r_state == c_ST_IDLE) && bus.in_valid;
    assign w_addend    = {{GUARD{1'b0}}, bus.xpb_value};
    assign w_carry_sh  = r_carry << 1;
    assign w_csa_sum   = r_sum ^ w_carry_sh ^ w_addend;
    assign w_csa_carry = (r_sum & w_carry_sh) | (r_sum & w_addend) | (w_carry_sh & w_addend);

    // Segment 0 is presented straight from the operand at accept, so the
    // shift register always holds the segments not yet put on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_shift     <= '0;
            r_seg_cnt   <= '0;
            r_sel       <= '0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= bus.in_high >> SEG_W;
                        r_sel     <= bus.in_high[SEG_W-1:0];
                        r_seg_cnt <= '0;
                        r_sum     <= {{GUARD{1'b0}}, bus.in_low};
                        r_carry   <= '0;
                        r_state   <= c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    r_sum   <= w_csa_sum;
                    r_carry <= w_csa_carry;
                    r_shift <= r_shift >> SEG_W;
                    if (r_seg_cnt == c_LAST_SEG) begin
                        r_seg_cnt <= '0;
                        r_sel     <= '0;
                        r_state   <= c_ST_RESOLVE;
                    end else begin
                        r_seg_cnt <= r_seg_cnt + 1'b1;
                        r_sel     <= r_shift[SEG_W-1:0];
                    end
                end
                c_ST_RESOLVE: begin
                    r_out_data  <= r_sum + (r_carry << 1);
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == c_ST_IDLE);
    assign bus.xpb_seg_idx = r_seg_cnt;
    assign bus.xpb_sel     = r_sel;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_xpb_reduce_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_xpb_reduce_accum
// Description : Directed bench for xpb_reduce_accum with a per-cycle model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_reduce_accum;
    localparam int DATA_W  = 1024;
    localparam int SEG_W   = 5;
    localparam int NUM_SEG = 32;
    localparam int GUARD   = 8;
    localparam int IDX_W   = 6;
    localparam int ACC_W   = DATA_W + GUARD;
    localparam int HIGH_W  = NUM_SEG * SEG_W;

    typedef logic [1055:0] wide_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_vec;
    int   n_miss;

    xpb_reduce_accum_if #(
        .DATA_W(DATA_W), .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .GUARD(GUARD), .IDX_W(IDX_W)
    ) bus ();

    xpb_reduce_accum #(
        .DATA_W(DATA_W), .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .GUARD(GUARD), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table bank: 0 -> (idx+1)*sel, 1 -> all ones for nonzero sel, 2 -> scattered pattern.
    function automatic logic [DATA_W-1:0] tbl(input int m, input int idx, input int sel);
        logic [DATA_W-1:0] v;
        if (sel == 0) return '0;
        case (m)
            0:       v = DATA_W'((idx + 1) * sel);
            1:       v = '1;
            default: begin
                v = DATA_W'(idx * 37 + sel * 1001 + 1);
                v = v << (idx * 31);
            end
        endcase
        return v;
    endfunction

    always_comb begin
        bus.xpb_value = tbl(mode, int'(bus.xpb_seg_idx), int'(bus.xpb_sel));
    end

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle model compare ----------------
    bit                busy;
    int                t;
    logic [ACC_W-1:0]  exp_res;
    logic [ACC_W-1:0]  held;
    logic [SEG_W-1:0]  exp_sel [NUM_SEG];

    initial begin
        busy = 0; t = 0; exp_res = '0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready",  wide_t'(bus.in_ready), 1);
                chk("rst_out_valid", wide_t'(bus.out_valid), 0);
                chk("rst_out_data",  wide_t'(bus.out_data), 0);
                chk("rst_seg_idx",   wide_t'(bus.xpb_seg_idx), 0);
                chk("rst_sel",       wide_t'(bus.xpb_sel), 0);
                busy = 0;
                held = '0;
            end else begin
                if (!busy) begin
                    chk("idle_in_ready",  wide_t'(bus.in_ready), 1);
                    chk("idle_out_valid", wide_t'(bus.out_valid), 0);
                    chk("idle_seg_idx",   wide_t'(bus.xpb_seg_idx), 0);
                    chk("idle_sel",       wide_t'(bus.xpb_sel), 0);
                    chk("idle_out_data",  wide_t'(bus.out_data), wide_t'(held));
                end else if (t < NUM_SEG) begin
                    chk("acc_in_ready",  wide_t'(bus.in_ready), 0);
                    chk("acc_out_valid", wide_t'(bus.out_valid), 0);
                    chk("acc_seg_idx",   wide_t'(bus.xpb_seg_idx), wide_t'(t));
                    chk("acc_sel",       wide_t'(bus.xpb_sel), wide_t'(exp_sel[t]));
                end else if (t == NUM_SEG) begin
                    chk("res_in_ready",  wide_t'(bus.in_ready), 0);
                    chk("res_out_valid", wide_t'(bus.out_valid), 0);
                    chk("res_seg_idx",   wide_t'(bus.xpb_seg_idx), 0);
                    chk("res_sel",       wide_t'(bus.xpb_sel), 0);
                end else begin
                    chk("hold_in_ready",  wide_t'(bus.in_ready), 0);
                    chk("hold_out_valid", wide_t'(bus.out_valid), 1);
                    chk("hold_out_data",  wide_t'(bus.out_data), wide_t'(exp_res));
                end
                // Predict what the coming edge does.
                if (!busy) begin
                    if (bus.in_valid) begin
                        busy = 1;
                        t = 0;
                        exp_res = ACC_W'(bus.in_low);
                        for (int k = 0; k < NUM_SEG; k++) begin
                            exp_sel[k] = bus.in_high[k*SEG_W +: SEG_W];
                            exp_res = exp_res + ACC_W'(tbl(mode, k, int'(exp_sel[k])));
                        end
                    end
                end else if (t > NUM_SEG && bus.out_ready) begin
                    busy = 0;
                    held = exp_res;
                end else begin
                    t++;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic accept(input logic [DATA_W-1:0] low, input logic [HIGH_W-1:0] high);
        int n;
        @(posedge clk); #2;
        bus.in_valid = 1'b1;
        bus.in_low   = low;
        bus.in_high  = high;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_bound", wide_t'(n < 200), 1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    // Called 2 time units after the accept edge.
    task automatic wait_valid(output logic [ACC_W-1:0] res, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #2;
            lat++;
        end
        res = bus.out_data;
    endtask

    task automatic run_op(input logic [DATA_W-1:0] low, input logic [HIGH_W-1:0] high,
                          output logic [ACC_W-1:0] res);
        int lat;
        accept(low, high);
        wait_valid(res, lat);
        chk("latency", wide_t'(lat), wide_t'(NUM_SEG + 1));
        @(posedge clk); #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ACC_W-1:0]  res;
        logic [HIGH_W-1:0] h;
        logic [DATA_W-1:0] ones;
        int                lat;
        int                n;

        n_vec = 0; n_miss = 0; mode = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_low = '0; bus.in_high = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: zero high part passes the low part through
        run_op(DATA_W'(5), '0, res);
        chk("t1_result", wide_t'(res), 5);

        // 2: every selector 0x1F with the (idx+1)*sel table
        run_op('0, '1, res);
        chk("t2_result", wide_t'(res), 16368);

        // 3: worst-case magnitudes must not truncate
        mode = 1;
        ones = '1;
        for (int i = 0; i < NUM_SEG; i++) h[i*SEG_W +: SEG_W] = SEG_W'(1);
        run_op(ones, h, res);
        chk("t3_result", wide_t'(res), wide_t'((ACC_W'(ones) << 5) + ACC_W'(ones)));
        mode = 0;

        // 4: stalled output, second operand pending during the stall
        accept(DATA_W'(11), '0);
        wait_valid(res, lat);
        chk("t4_latency", wide_t'(lat), wide_t'(NUM_SEG + 1));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_low    = DATA_W'(22);
        bus.in_high   = HIGH_W'(3);
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("t4_held_data", wide_t'(bus.out_data), 11);
        chk("t4_in_ready_stall", wide_t'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        chk("t4_idle_visit", wide_t'(bus.in_ready), 1);
        chk("t4_valid_dropped", wide_t'(bus.out_valid), 0);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        wait_valid(res, lat);
        chk("t4_second_latency", wide_t'(lat), wide_t'(NUM_SEG + 1));
        chk("t4_second_result", wide_t'(res), 25);
        @(posedge clk); #2;

        // 5: asynchronous reset in the middle of an operation
        accept(DATA_W'(100), '1);
        n = 0;
        while (bus.xpb_seg_idx != IDX_W'(10) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("t5_reach_seg10", wide_t'(bus.xpb_seg_idx), 10);
        rst_n = 1'b0;
        #1;
        chk("t5_async_idx", wide_t'(bus.xpb_seg_idx), 0);
        chk("t5_async_sel", wide_t'(bus.xpb_sel), 0);
        chk("t5_async_in_ready", wide_t'(bus.in_ready), 1);
        chk("t5_async_out_valid", wide_t'(bus.out_valid), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(DATA_W'(7), '0, res);
        chk("t5_result", wide_t'(res), 7);

        // 6: random selectors; the model compare walks idx/sel every cycle
        mode = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < HIGH_W / 32; i++) h[i*32 +: 32] = $urandom;
            run_op(DATA_W'($urandom), h, res);
        end
        mode = 0;

        // selector 0 in every other segment: (idx+1)*sel over odd idx with sel=2
        for (int i = 0; i < NUM_SEG; i++) h[i*SEG_W +: SEG_W] = (i % 2 == 1) ? SEG_W'(2) : SEG_W'(0);
        run_op(DATA_W'(1), h, res);
        chk("odd_seg_result", wide_t'(res), 1 + 2 * 272);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
